wb_port_arbiter: RTL and testbench

Shares the single register-file write port between the in-order pipeline writeback (the MEM/WB result) and the multi-cycle mul/div unit (MDU).
- The pipeline has priority. MDU results wait in a small in-order queue.
- A starvation counter forces a one-cycle pipeline stall so a queued MDU result can drain.
- Sits between the writeback stage / MDU and the register file. Exports a pending-rd mask to the hazard unit.

---
 rtl/wb_port_arbiter.sv | 97 +++++++++
 tb/tb_wb_port_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between pipeline writeback and a queued MDU result stream.
// Optional WB_MDU_BYPASS_EN: an MDU result arriving while idle with no pipeline write goes straight to the register file.
module wb_port_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pipe_wb_en,
  input  logic [4:0]               pipe_wb_rd,
  input  logic [31:0]              pipe_wb_data,
  input  logic                     mdu_valid,
  input  logic [4:0]               mdu_rd,
  input  logic [31:0]              mdu_data,
  output logic                     mdu_ready,
  output logic                     rf_we,
  output logic [4:0]               rf_waddr,
  output logic [31:0]              rf_wdata,
  output logic                     pipe_stall,
  output logic [31:0]              pend_mask,
  output logic [$clog2(DEPTH):0]   pend_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = MAX_WAIT > 1 ? $clog2(MAX_WAIT) : 1;
  typedef enum logic [1:0] {IDLE, PEND, FORCE} state_t;
  state_t state, state_nxt;
  logic [4:0]       rd_q   [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [AW-1:0]    wptr, rptr;
  logic [CW-1:0]    count, count_nxt;
  logic [WW-1:0]    wait_cnt, wait_nxt;
  logic             pipe_req, byp, enq, deq, force_go;
  assign pipe_req  = pipe_wb_en & (pipe_wb_rd != 5'd0);
  assign mdu_ready = count != CW'(DEPTH);
`ifdef WB_MDU_BYPASS_EN
  assign byp = (state == IDLE) & ~pipe_req & mdu_valid & (mdu_rd != 5'd0);
`else
  assign byp = 1'b0;
`endif
  assign enq       = mdu_valid & mdu_ready & (mdu_rd != 5'd0) & ~byp;
  assign deq       = (state == FORCE) | ((state == PEND) & ~pipe_req);
  assign force_go  = (state == PEND) & pipe_req & (wait_cnt == WW'(MAX_WAIT - 1));
  assign count_nxt = count + CW'(enq) - CW'(deq);
  // wait_cnt tracks consecutive losses of the current head only
  assign wait_nxt  = ((state == PEND) & pipe_req & ~force_go) ? wait_cnt + 1'b1 : '0;
  assign pend_count = count;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end
  always_comb begin
    state_nxt = force_go ? FORCE : (count_nxt != '0) ? PEND : IDLE;
  end
  // rf_we is gated by rst_n so no write escapes while reset is held
  always_comb begin
    pipe_stall = state == FORCE;
    rf_we      = rst_n & (pipe_req | deq | byp);
    rf_waddr   = deq ? rd_q[rptr]   : byp ? mdu_rd   : pipe_wb_rd;
    rf_wdata   = deq ? data_q[rptr] : byp ? mdu_data : pipe_wb_data;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      vld   <= '0;
    end else begin
      if (enq) begin
        vld[wptr] <= 1'b1;
        wptr      <= wptr + 1'b1;
      end
      if (deq) begin
        vld[rptr] <= 1'b0;
        rptr      <= rptr + 1'b1;
      end
      count <= count_nxt;
    end
  end
  always_ff @(posedge clk) begin
    if (enq) begin
      rd_q[wptr]   <= mdu_rd;
      data_q[wptr] <= mdu_data;
    end
  end
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (vld[i]) pend_mask[rd_q[i]] = 1'b1;
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed stimulus, queue-based reference model checked every cycle, plus literal expectations.
module tb_wb_port_arbiter;
  localparam int DEPTH = 2;
  localparam int MAX_WAIT = 4;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        pipe_wb_en = 1'b0, mdu_valid = 1'b0;
  logic [4:0]  pipe_wb_rd = '0, mdu_rd = '0;
  logic [31:0] pipe_wb_data = '0, mdu_data = '0;
  logic        mdu_ready, rf_we, pipe_stall;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, pend_mask;
  logic [$clog2(DEPTH):0] pend_count;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  wb_port_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_wb_en(pipe_wb_en), .pipe_wb_rd(pipe_wb_rd), .pipe_wb_data(pipe_wb_data),
    .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pipe_stall(pipe_stall), .pend_mask(pend_mask), .pend_count(pend_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct packed {logic [4:0] rd; logic [31:0] data;} ent_t;
  ent_t q[$];
  int   losses = 0;
  bit   forcing = 0;

  // Reference: a plain FIFO of pending results, a loss counter for the head, and a forced-drain flag
  always @(negedge clk) begin : model
    logic pr, ewe, byp, acc, dq, nf;
    logic [4:0] ea;
    logic [31:0] ed, em;
    if (!rst_n) begin
      q.delete();
      losses = 0;
      forcing = 0;
      chk("m_rst_we", 32'(rf_we), 0);
      chk("m_rst_count", 32'(pend_count), 0);
      chk("m_rst_mask", pend_mask, 0);
      chk("m_rst_stall", 32'(pipe_stall), 0);
    end else begin
      pr = pipe_wb_en && pipe_wb_rd != 5'd0;
      ewe = 0; byp = 0; dq = 0; ea = '0; ed = '0;
      if (forcing) begin
        ewe = 1; ea = q[0].rd; ed = q[0].data; dq = 1;
      end else if (q.size() != 0) begin
        ewe = 1;
        if (pr) begin ea = pipe_wb_rd; ed = pipe_wb_data; end
        else begin ea = q[0].rd; ed = q[0].data; dq = 1; end
      end else if (pr) begin
        ewe = 1; ea = pipe_wb_rd; ed = pipe_wb_data;
      end
`ifdef WB_MDU_BYPASS_EN
      else if (mdu_valid && mdu_rd != 5'd0) begin
        ewe = 1; ea = mdu_rd; ed = mdu_data; byp = 1;
      end
`endif
      em = '0;
      foreach (q[i]) em[q[i].rd] = 1'b1;
      chk("m_we", 32'(rf_we), 32'(ewe));
      chk("m_stall", 32'(pipe_stall), 32'(forcing));
      chk("m_ready", 32'(mdu_ready), 32'(q.size() != DEPTH));
      chk("m_count", 32'(pend_count), 32'(q.size()));
      chk("m_mask", pend_mask, em);
      if (ewe) begin
        chk("m_waddr", 32'(rf_waddr), 32'(ea));
        chk("m_wdata", rf_wdata, ed);
      end
      acc = mdu_valid && q.size() != DEPTH && mdu_rd != 5'd0 && !byp;
      nf = !forcing && q.size() != 0 && pr && losses + 1 == MAX_WAIT;
      losses = (!forcing && q.size() != 0 && pr && !nf) ? losses + 1 : 0;
      if (dq) void'(q.pop_front());
      if (acc) q.push_back('{rd: mdu_rd, data: mdu_data});
      forcing = nf;
    end
  end

  task automatic cyc(input logic pe, input logic [4:0] prd, input logic [31:0] pd,
                     input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    @(posedge clk);
    #1;
    pipe_wb_en = pe; pipe_wb_rd = prd; pipe_wb_data = pd;
    mdu_valid = mv; mdu_rd = mrd; mdu_data = md;
    @(negedge clk);
  endtask

  initial begin
    logic [4:0]  got_rd [6];
    logic [31:0] got_d  [6];
    logic pe;
    int item, nw;
    repeat (2) @(negedge clk);
    chk("reset_we", 32'(rf_we), 0);
    chk("reset_count", 32'(pend_count), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0, 0);
    chk("ready_after_reset", 32'(mdu_ready), 1);
`ifndef WB_MDU_BYPASS_EN
    // MDU alone
    cyc(0, 0, 0, 1, 5, 32'h7);
    chk("t2_no_same_cycle_write", 32'(rf_we), 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("t2_we", 32'(rf_we), 1);
    chk("t2_waddr", 32'(rf_waddr), 5);
    chk("t2_wdata", rf_wdata, 32'h7);
    chk("t2_mask", pend_mask, 32'h20);
    cyc(0, 0, 0, 0, 0, 0);
    chk("t2_mask_clear", pend_mask, 0);
    chk("t2_we_clear", 32'(rf_we), 0);
    // priority and starvation
    cyc(0, 0, 0, 1, 3, 32'h33);
    for (int i = 1; i <= 4; i++) begin
      cyc(1, 5'(i), 32'(256 + i), 0, 0, 0);
      chk($sformatf("t3_pipe_addr%0d", i), 32'(rf_waddr), 32'(i));
      chk($sformatf("t3_pipe_stall%0d", i), 32'(pipe_stall), 0);
    end
    cyc(1, 5, 32'h105, 0, 0, 0);
    chk("t3_force_stall", 32'(pipe_stall), 1);
    chk("t3_force_addr", 32'(rf_waddr), 3);
    chk("t3_force_data", rf_wdata, 32'h33);
    cyc(1, 5, 32'h105, 0, 0, 0);
    chk("t3_replay_stall", 32'(pipe_stall), 0);
    chk("t3_replay_addr", 32'(rf_waddr), 5);
    // full queue
    cyc(1, 7, 32'h77, 1, 8, 32'h88);
    chk("t4_pipe_addr", 32'(rf_waddr), 7);
    cyc(1, 7, 32'h77, 1, 9, 32'h99);
    chk("t4_ready1", 32'(mdu_ready), 1);
    cyc(1, 7, 32'h77, 1, 10, 32'hAA);
    chk("t4_full_ready", 32'(mdu_ready), 0);
    chk("t4_full_count", 32'(pend_count), 2);
    chk("t4_full_mask", pend_mask, 32'h300);
    cyc(0, 0, 0, 1, 10, 32'hAA);
    chk("t4_deq_ready", 32'(mdu_ready), 0);
    chk("t4_deq_addr", 32'(rf_waddr), 8);
    chk("t4_deq_data", rf_wdata, 32'h88);
    cyc(0, 0, 0, 0, 0, 0);
    chk("t4_ready_back", 32'(mdu_ready), 1);
    chk("t4_count1", 32'(pend_count), 1);
    chk("t4_addr9", 32'(rf_waddr), 9);
    cyc(0, 0, 0, 0, 0, 0);
    chk("t4_empty", 32'(pend_count), 0);
`endif
    // x0 filtering
    cyc(1, 0, 32'hDEAD, 1, 0, 32'hBEEF);
    chk("t5_we", 32'(rf_we), 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("t5_count", 32'(pend_count), 0);
    // ordering across pointer wrap
    item = 0;
    nw = 0;
    for (int k = 0; k < 30 && nw < 6; k++) begin
      pe = 1'(k % 2);
      cyc(pe, 5'd20, 32'(512 + k), item < 6, 5'(10 + item), 32'(208 + 10 + item));
      if (rf_we && !pe) begin
        got_rd[nw] = rf_waddr;
        got_d[nw] = rf_wdata;
        nw++;
      end
      if (item < 6 && mdu_ready) item++;
    end
    chk("t6_writes", 32'(nw), 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t6_rd%0d", i), 32'(got_rd[i]), 32'(10 + i));
      chk($sformatf("t6_data%0d", i), got_d[i], 32'(208 + 10 + i));
    end
    // reset mid-operation
    cyc(1, 2, 32'h22, 1, 17, 32'h1717);
    cyc(1, 2, 32'h22, 1, 18, 32'h1818);
    @(posedge clk);
    #1;
    chk("t1_before_count", 32'(pend_count), 2);
    rst_n = 1'b0;
    mdu_valid = 1'b0;
    #1;
    chk("t1_count", 32'(pend_count), 0);
    chk("t1_mask", pend_mask, 0);
    chk("t1_stall", 32'(pipe_stall), 0);
    chk("t1_we", 32'(rf_we), 0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pipe_wb_en = 1'b0;
    @(negedge clk);
    chk("t1_ready_after", 32'(mdu_ready), 1);
    chk("t1_count_after", 32'(pend_count), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
